// File: rtl/key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per clock into a registered 1408-bit bus.
// Round 0 (cipher key) sits at [1407:1280] and round 10 at [127:0]. A start pulse begins a 10-cycle expansion, and done holds until the next start.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);
  localparam logic [0:255][7:0] TBL = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  assign d = TBL[a];
endmodule

module key_expand_seq #(
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  key_in,
  output logic          busy,
  output logic          done,
  output logic [3:0]    round,
  output logic [1407:0] words
);
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state;
  logic [7:0]   rcon;
  logic [127:0] prev;
  logic [127:0] nxt;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [31:0]  g;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon_nxt;
  logic [3:0]   round_nxt;

  // Previous round key is whichever slot the round counter points at.
  always_comb begin
    prev = '0;
    for (int i = 0; i <= NR; i++) begin
      if (round == 4'(i)) prev = words[1407-128*i -: 128];
    end
  end

  assign rot = {prev[23:0], prev[31:24]};

  aes_sbox u_sb3 (.a(rot[31:24]), .d(sub[31:24]));
  aes_sbox u_sb2 (.a(rot[23:16]), .d(sub[23:16]));
  aes_sbox u_sb1 (.a(rot[15:8]),  .d(sub[15:8]));
  aes_sbox u_sb0 (.a(rot[7:0]),   .d(sub[7:0]));

  assign g         = sub ^ {rcon, 24'h0};
  assign n0        = prev[127:96] ^ g;
  assign n1        = prev[95:64]  ^ n0;
  assign n2        = prev[63:32]  ^ n1;
  assign n3        = prev[31:0]   ^ n2;
  assign nxt       = {n0, n1, n2, n3};
  assign rcon_nxt  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign round_nxt = round + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      round <= 4'd0;
      words <= '0;
      rcon  <= 8'h01;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            words <= {key_in, 1280'b0};
            round <= 4'd0;
            rcon  <= 8'h01;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          if (round != LAST) begin
            for (int i = 1; i <= NR; i++) begin
              if (round_nxt == 4'(i)) words[1407-128*i -: 128] <= nxt;
            end
            round <= round_nxt;
            rcon  <= rcon_nxt;
          end
          if (round_nxt >= LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_expand_seq.sv
// Directed bench for key_expand_seq using FIPS-197 key-expansion vectors and handshake timing checks.
module tb_key_expand_seq;
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  key_in;
  logic          busy;
  logic          done;
  logic [3:0]    round;
  logic [1407:0] words;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] K_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_ZERO = 128'h0;

  key_expand_seq #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .round(round), .words(words)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = ~k;
  endtask

  // Observes cycles 0..14 after the start edge; optionally re-pulses start before edge inj_at.
  task automatic run_watch(input int inj_at, input logic [127:0] inj_key,
                           output int dc, output int bc, output logic [127:0] slot1);
    dc = -1;
    bc = 0;
    slot1 = 'x;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) begin
        if (c == inj_at) begin
          @(negedge clk);
          key_in = inj_key;
          start  = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (busy) bc++;
      if (done && dc < 0) dc = c;
      if (c == 1) slot1 = words[1279:1152];
    end
  endtask

  int dc, bc;
  logic [127:0] s1;

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    key_in = '0;
    #2 rst = 1'b1;
    #1;
    check("reset_busy",  {127'b0, busy}, 128'd0);
    check("reset_done",  {127'b0, done}, 128'd0);
    check("reset_round", {124'b0, round}, 128'd0);
    check("reset_words", {127'b0, (words == '0)}, 128'd1);

    // rst and start together on an edge: rst wins
    @(negedge clk);
    start  = 1'b1;
    key_in = K_A1;
    @(posedge clk);
    #1;
    check("rst_start_busy", {127'b0, busy}, 128'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;

    // FIPS-197 A.1
    start_pulse(K_A1);
    check("a1_e0_busy",  {127'b0, busy}, 128'd1);
    check("a1_e0_done",  {127'b0, done}, 128'd0);
    check("a1_e0_round", {124'b0, round}, 128'd0);
    check("a1_slot0",    words[1407:1280], K_A1);
    run_watch(-1, '0, dc, bc, s1);
    check("a1_slot1",    s1, 128'ha0fafe1788542cb123a339392a6c7605);
    check("a1_slot10",   words[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("a1_done_cyc", 128'(dc), 128'd10);
    check("a1_busy_cyc", 128'(bc), 128'd10);
    check("a1_round",    {124'b0, round}, 128'd10);

    // Start while busy is ignored
    start_pulse(K_SEQ);
    run_watch(4, K_A1, dc, bc, s1);
    check("busy_slot1",    s1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("busy_slot10",   words[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("busy_slot0",    words[1407:1280], K_SEQ);
    check("busy_done_cyc", 128'(dc), 128'd10);
    check("busy_busy_cyc", 128'(bc), 128'd10);

    // Restart from DONE with all-zero key
    start_pulse(K_ZERO);
    check("rs_done_drop", {127'b0, done}, 128'd0);
    check("rs_cleared",   {127'b0, (words[1279:0] == '0)}, 128'd1);
    run_watch(-1, '0, dc, bc, s1);
    check("rs_slot1",    s1, 128'h62636363626363636263636362636363);
    check("rs_slot10",   words[127:0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check("rs_done_cyc", 128'(dc), 128'd10);

    // Reset in the middle of an expansion, then a clean run
    start_pulse(K_A1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_busy",  {127'b0, busy}, 128'd0);
    check("mid_done",  {127'b0, done}, 128'd0);
    check("mid_round", {124'b0, round}, 128'd0);
    check("mid_words", {127'b0, (words == '0)}, 128'd1);
    @(negedge clk);
    rst = 1'b0;
    start_pulse(K_SEQ);
    run_watch(-1, '0, dc, bc, s1);
    check("post_slot10",   words[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("post_done_cyc", 128'(dc), 128'd10);
    check("post_done",     {127'b0, done}, 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
